// File: rtl/regload_arb.sv
// rtl/regload_arb.sv - two-port handshaked register load decoder with collision serialisation
module regload_arb #(
    parameter int ADDR_W    = 6,
    parameter int NREGS     = 32,
    parameter int ZERO_PROT = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_sel,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_sel,
    output logic              b_ready,
    output logic [NREGS-1:0]  regloads,
    output logic              pend_valid,
    output logic              err_oor,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [ADDR_W:0] NREGS_V = (ADDR_W+1)'(NREGS);

    logic [ADDR_W-1:0] pend_sel;
    logic              a_xfer;
    logic              b_xfer;
    logic              ab_coll;
    logic              a_pend_coll;
    logic              oor_hit;
    logic [NREGS-1:0]  next_loads;

    function automatic logic in_range(input logic [ADDR_W-1:0] s);
        return {1'b0, s} < NREGS_V;
    endfunction

    function automatic logic effective(input logic [ADDR_W-1:0] s);
        return in_range(s) && !((ZERO_PROT != 0) && (s == '0));
    endfunction

    // A only stalls on a genuine same-register hit against the older pending entry
    assign a_pend_coll = pend_valid && a_valid && effective(a_sel)
                         && effective(pend_sel) && (a_sel == pend_sel);
    assign a_ready = en && !a_pend_coll;
    assign b_ready = en && !pend_valid;

    assign a_xfer  = a_valid && a_ready;
    assign b_xfer  = b_valid && b_ready;
    assign ab_coll = a_xfer && b_xfer && effective(a_sel) && effective(b_sel)
                     && (a_sel == b_sel);
    assign oor_hit = (a_xfer && !in_range(a_sel)) || (b_xfer && !in_range(b_sel));

    always_comb begin
        next_loads = '0;
        for (int i = 0; i < NREGS; i++) begin
            next_loads[i] = (pend_valid && en && (pend_sel == ADDR_W'(i)))
                          || (a_xfer && (a_sel == ADDR_W'(i)))
                          || (b_xfer && !ab_coll && (b_sel == ADDR_W'(i)));
        end
        if (ZERO_PROT != 0) begin
            next_loads[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regloads     <= '0;
            pend_valid   <= 1'b0;
            pend_sel     <= '0;
            err_oor      <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            regloads <= next_loads;
            if (oor_hit) begin
                err_oor <= 1'b1;
            end
            // Collision: A issues now, B waits one cycle in the pending buffer
            if (ab_coll) begin
                pend_valid <= 1'b1;
                pend_sel   <= b_sel;
                if (conflict_cnt != '1) begin
                    conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
            end else if (en && pend_valid) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regload_arb.sv
// tb/tb_regload_arb.sv - directed self-checking bench for regload_arb
module tb_regload_arb;

    logic        clk;
    logic        rst;
    logic        en;
    logic        a_valid;
    logic [5:0]  a_sel;
    logic        a_ready;
    logic        b_valid;
    logic [5:0]  b_sel;
    logic        b_ready;
    logic [31:0] regloads;
    logic        pend_valid;
    logic        err_oor;
    logic [7:0]  conflict_cnt;

    int asserts;
    int failures;

    regload_arb #(.ADDR_W(6), .NREGS(32), .ZERO_PROT(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a_valid(a_valid), .a_sel(a_sel), .a_ready(a_ready),
        .b_valid(b_valid), .b_sel(b_sel), .b_ready(b_ready),
        .regloads(regloads), .pend_valid(pend_valid),
        .err_oor(err_oor), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [5:0] as, input logic bv, input logic [5:0] bs);
        a_valid = av;
        a_sel   = as;
        b_valid = bv;
        b_sel   = bs;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        step();
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL reset_regloads got %h want %h", regloads, 32'h0); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL reset_pend got %b want 0", pend_valid); end
        asserts++; if (err_oor !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err_oor); end
        asserts++; if (conflict_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        drive(1'b1, 6'd5, 1'b1, 6'd9);
        asserts++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got a=%b b=%b want 1 1", a_ready, b_ready); end
        step();
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        asserts++; if (regloads !== 32'h0000_0220) begin failures++; $display("FAIL basic_loads got %h want %h", regloads, 32'h220); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL basic_pend got %b want 0", pend_valid); end
        step();
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL basic_idle got %h want 0", regloads); end
    endtask

    task automatic test_collision();
        drive(1'b1, 6'd7, 1'b1, 6'd7);
        step();
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        asserts++; if (regloads !== 32'h80) begin failures++; $display("FAIL coll_first got %h want %h", regloads, 32'h80); end
        asserts++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL coll_pend got %b want 1", pend_valid); end
        asserts++; if (b_ready !== 1'b0) begin failures++; $display("FAIL coll_bready got %b want 0", b_ready); end
        step();
        asserts++; if (regloads !== 32'h80) begin failures++; $display("FAIL coll_second got %h want %h", regloads, 32'h80); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL coll_drain got %b want 0", pend_valid); end
        asserts++; if (conflict_cnt !== 8'd1) begin failures++; $display("FAIL coll_cnt got %0d want 1", conflict_cnt); end
    endtask

    task automatic test_stall();
        drive(1'b1, 6'd3, 1'b1, 6'd3);
        step();
        drive(1'b1, 6'd3, 1'b0, 6'd0);
        asserts++; if (regloads !== 32'h8) begin failures++; $display("FAIL stall_a_first got %h want %h", regloads, 32'h8); end
        asserts++; if (a_ready !== 1'b0) begin failures++; $display("FAIL stall_aready got %b want 0", a_ready); end
        step();
        asserts++; if (regloads !== 32'h8) begin failures++; $display("FAIL stall_pend_issue got %h want %h", regloads, 32'h8); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL stall_pend got %b want 0", pend_valid); end
        asserts++; if (a_ready !== 1'b1) begin failures++; $display("FAIL stall_release got %b want 1", a_ready); end
        step();
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        asserts++; if (regloads !== 32'h8) begin failures++; $display("FAIL stall_a_late got %h want %h", regloads, 32'h8); end
        asserts++; if (conflict_cnt !== 8'd2) begin failures++; $display("FAIL stall_cnt got %0d want 2", conflict_cnt); end
        step();
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL stall_idle got %h want 0", regloads); end
    endtask

    task automatic test_zero_oor();
        drive(1'b1, 6'd0, 1'b1, 6'd40);
        asserts++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL zo_ready got a=%b b=%b want 1 1", a_ready, b_ready); end
        step();
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL zo_loads got %h want 0", regloads); end
        asserts++; if (err_oor !== 1'b1) begin failures++; $display("FAIL zo_err got %b want 1", err_oor); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL zo_pend got %b want 0", pend_valid); end
        step(); step();
        asserts++; if (err_oor !== 1'b1) begin failures++; $display("FAIL zo_sticky got %b want 1", err_oor); end
        asserts++; if (conflict_cnt !== 8'd2) begin failures++; $display("FAIL zo_cnt got %0d want 2", conflict_cnt); end
    endtask

    task automatic test_en_hold();
        drive(1'b1, 6'd12, 1'b1, 6'd12);
        step();
        en = 1'b0;
        drive(1'b1, 6'd1, 1'b1, 6'd2);
        asserts++; if (regloads !== 32'h1000) begin failures++; $display("FAIL en_a got %h want %h", regloads, 32'h1000); end
        asserts++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL en_ready got a=%b b=%b want 0 0", a_ready, b_ready); end
        step();
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL en_frozen got %h want 0", regloads); end
        asserts++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL en_hold got %b want 1", pend_valid); end
        step();
        asserts++; if (pend_valid !== 1'b1) begin failures++; $display("FAIL en_hold2 got %b want 1", pend_valid); end
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        en = 1'b1;
        step();
        asserts++; if (regloads !== 32'h1000) begin failures++; $display("FAIL en_resume got %h want %h", regloads, 32'h1000); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL en_drain got %b want 0", pend_valid); end
        asserts++; if (conflict_cnt !== 8'd3) begin failures++; $display("FAIL en_cnt got %0d want 3", conflict_cnt); end
        drive(1'b1, 6'd20, 1'b1, 6'd20);
        step();
        drive(1'b0, 6'd0, 1'b0, 6'd0);
        rst = 1'b1;
        #1;
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL arst_loads got %h want 0", regloads); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL arst_pend got %b want 0", pend_valid); end
        asserts++; if (err_oor !== 1'b0) begin failures++; $display("FAIL arst_err got %b want 0", err_oor); end
        asserts++; if (conflict_cnt !== 8'd0) begin failures++; $display("FAIL arst_cnt got %0d want 0", conflict_cnt); end
        step();
        rst = 1'b0;
        step();
        asserts++; if (regloads !== 32'h0) begin failures++; $display("FAIL arst_nopend got %h want 0", regloads); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 6'd5, 1'b1, 6'd5);
            step();
            drive(1'b0, 6'd0, 1'b0, 6'd0);
            step();
            if (i == 253) begin
                asserts++; if (conflict_cnt !== 8'd254) begin failures++; $display("FAIL sat_pre got %0d want 254", conflict_cnt); end
            end
        end
        asserts++; if (conflict_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt got %0d want 255", conflict_cnt); end
        asserts++; if (pend_valid !== 1'b0) begin failures++; $display("FAIL sat_pend got %b want 0", pend_valid); end
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_collision();
        test_stall();
        test_zero_oor();
        test_en_hold();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/regload_arb.md
Name: regload_arb

Overview:
Parametrised, registered successor to the register-file load decoder. It accepts write-back register selects from two write ports (A and B) through a valid/ready handshake and decodes them into a one-hot-per-port register load vector. Same-register collisions are serialised through a single-entry pending buffer. It sits between the write-back stage and the register file load enables.

Parameters:
ADDR_W, 6, width of each select input; matches the existing 6-bit load select.
NREGS, 32, number of registers/load lines; legal range 1..2**ADDR_W.
ZERO_PROT, 1, when 1 register 0 is never loaded (select 0 is accepted and produces no load bit).
CNT_W, 8, width of the saturating conflict counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  global enable; 0 freezes the block
a_valid  input  1  port A request
a_sel  input  ADDR_W  port A register select
a_ready  output  1  port A accept (combinational)
b_valid  input  1  port B request
b_sel  input  ADDR_W  port B register select
b_ready  output  1  port B accept (combinational)
regloads  output  NREGS  registered load enables, up to two bits set
pend_valid  output  1  pending buffer occupied
err_oor  output  1  sticky flag: an out-of-range select was accepted
conflict_cnt  output  CNT_W  saturating count of A/B same-register collisions

Behaviour:
- Reset (async, rst=1): regloads=0, pend_valid=0, pend_sel=0, err_oor=0, conflict_cnt=0. A reset mid-operation discards any pending entry.
- Select classes:
  - "effective": sel < NREGS and not (ZERO_PROT and sel==0).
  - "out-of-range": sel >= NREGS. The request is accepted, no load bit is produced, and err_oor is set. err_oor clears only on reset.
  - Two requests "collide" only when both are effective and their selects are equal.
- Handshake: a transfer occurs when valid && ready on a rising edge. Ready is purely combinational from en, pend_valid, pend_sel, a_valid and a_sel; it never depends on b_valid for port A.
  - b_ready = en && !pend_valid.
  - a_ready = en && !(pend_valid && a_valid && a_sel collides with pend_sel).
- en=0: both readies are 0, nothing issues, the pending buffer holds, and regloads is 0 on the next edge.
- Issue set for each cycle with en=1:
  - The pending entry always issues if pend_valid, because it is the oldest request.
  - A issues if it transfers.
  - B issues if it transfers and does not collide with A.
  - If A and B both transfer and collide: A issues, B's select is captured into pend_sel, pend_valid is set, and conflict_cnt increments (saturating at all-ones). B is still considered accepted.
  - pend_valid clears on the edge at which the pending entry issues, unless it is refilled in the same cycle. Refill is impossible while occupied because b_ready=0.
- Output: regloads on the next edge is the OR of the one-hot decodes of all issued effective selects. Latency is 1 cycle from transfer to load bit, or 2 cycles for a buffered B.
- Ordering: for a collision, A's load bit appears strictly one cycle before B's load bit for the same register. A younger A to the pending register stalls until the pending entry drains.
- At most two regloads bits are set per cycle. With ZERO_PROT=1, bit 0 is never set.

Test Plan:
- Reset, then A: sel=5, B: sel=9, en=1 -> next cycle regloads=0x00000220, both ready high, pend_valid=0.
- A and B both sel=7 -> cycle+1 regloads=0x80 with pend_valid=1 and b_ready=0; cycle+2 regloads=0x80 with pend_valid=0; conflict_cnt=1.
- Collision on reg 3, then next cycle A sel=3 -> a_ready=0 that cycle and regloads=0x8 from pending; A accepted the following cycle, with its bit set one cycle later.
- A sel=0 (ZERO_PROT=1), B sel=40 -> both accepted, regloads=0, err_oor=1, and err_oor stays 1 until rst.
- en=0 while pend_valid=1 -> readies 0, regloads=0, pending held; after en=1 the pending bit issues; assert rst mid-sequence -> all outputs 0 immediately.
- 300 back-to-back collisions with CNT_W=8 -> conflict_cnt saturates at 255.
